// File: rtl/phrase_sequencer.sv
// phrase_sequencer
//   Queues phrase requests and expands each phrase ID into its list of
//   phoneme codes. Codes go to the speech block one at a time over
//   data/write. After each code the sequencer waits for busy to rise and
//   then fall. If busy never rises, it moves on after a timeout.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_phrase   phrase ID to speak
//   req_valid    request strobe, taken when req_valid & req_ready
//   req_ready    queue not full (registered)
//   busy         busy from the speech block
//   data         phoneme code to the speech block
//   write        one-cycle load strobe for data
//   phrase_busy  high from the pop of a phrase until its done pulse
//   done         one-cycle pulse after the last phoneme of a phrase
//
// State table
//   S_IDLE    | wait for a queued request, pop it, latch start pointer
//   S_LOAD    | present ptr to the entry ROM
//   S_FETCH   | ROM output valid, capture {last, code}
//   S_ISSUE   | pulse write, clear the timeout counter
//   S_WAIT_HI | wait for busy to rise, or for the timeout
//   S_WAIT_LO | wait for busy to fall, then next entry or finish
//   S_FINISH  | pulse done, drop phrase_busy
module phrase_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int HI_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_phrase,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       busy,
    output logic [5:0] data,
    output logic       write,
    output logic       phrase_busy,
    output logic       done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(HI_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [4:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic [CW-1:0] count, count_next;
    logic          push, pop;

    logic [7:0]    ptr;
    logic [6:0]    rom_q;
    logic          last_r;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Start address of each phrase in the entry ROM. Every unused ID
    // points at one shared "silent" entry.
    function automatic logic [7:0] start_addr(input logic [4:0] id);
        case (id)
            5'd0:    start_addr = 8'h00;
            5'd1:    start_addr = 8'h04;
            default: start_addr = 8'h08;
        endcase
    endfunction

    // Entry ROM contents: {last, code[5:0]}.
    function automatic logic [6:0] rom_lookup(input logic [7:0] addr);
        case (addr)
            8'h00:   rom_lookup = 7'h2B;
            8'h01:   rom_lookup = 7'h3C;
            8'h02:   rom_lookup = 7'h35;
            8'h03:   rom_lookup = 7'h42;
            8'h04:   rom_lookup = 7'h2E;
            8'h05:   rom_lookup = 7'h0F;
            8'h06:   rom_lookup = 7'h0B;
            8'h07:   rom_lookup = 7'h42;
            8'h08:   rom_lookup = 7'h40;
            default: rom_lookup = 7'h40;
        endcase
    endfunction

    // Request queue
    assign push = req_valid & req_ready;
    assign pop  = (state == S_IDLE) && (count != '0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx] <= req_phrase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            count     <= count_next;
            req_ready <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // The ROM is read every cycle from ptr. ptr is stable through LOAD, so
    // the registered word is valid in FETCH.
    always_ff @(posedge clk) begin
        rom_q <= rom_lookup(ptr);
    end

    assign tmo_hit = (tmo_cnt == TW'(HI_TIMEOUT - 1));

    // FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        write      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD:  state_next = S_FETCH;
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: begin
                write      = 1'b1;
                state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy || tmo_hit) begin
                    state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    state_next = last_r ? S_FINISH : S_LOAD;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers driven by the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            data        <= '0;
            last_r      <= 1'b0;
            tmo_cnt     <= '0;
            phrase_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ptr         <= start_addr(fifo_mem[rd_idx]);
                        phrase_busy <= 1'b1;
                    end
                end
                S_FETCH: begin
                    data   <= rom_q[5:0];
                    last_r <= rom_q[6];
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT_HI: begin
                    if (!busy && !tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!busy && !last_r) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_FINISH: phrase_busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
